search_and_add_sched: RTL and testbench
=======================================

Name: search_and_add_sched

Overview:
- Batch scheduler in front of search_and_add in the wordcount pipeline.
- Accepts word records (128-bit key + 32-bit count) from an upstream valid/ready stream and writes them into the engine's input FIFO, honouring full.
- Closes a batch on size limit, upstream last, or idle timeout, then kicks the engine with data_num and waits for completion before starting the next batch.

Parameters:
- MAX_BATCH, 255, records per batch; legal range 1..255, fits data_num.
- TIMEOUT, 1024, cycles after the first record of a batch before a partial batch is forced out; 0 disables.
- KICK_GUARD, 2, cycles after the kick pulse during which sa_busy is ignored.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- s_valid  in  1  upstream record valid
- s_data  in  160  {key[127:0], count[31:0]}
- s_last  in  1  end of stream; closes the batch containing this record
- s_ready  out  1  upstream accept
- sa_ready  in  1  engine initialised
- sa_din  out  160  engine FIFO data
- sa_we  out  1  engine FIFO write
- sa_full  in  1  engine FIFO full
- sa_kick  out  1  one-cycle batch start
- sa_data_num  out  8  records in the kicked batch
- sa_busy  in  1  engine processing
- batch_cnt  out  32  batches kicked, wraps
- word_cnt  out  32  records forwarded, wraps
- idle  out  1  high in FILL with zero records pending

Behaviour:
- Reset values: s_ready=0, sa_we=0, sa_kick=0, sa_din=0, sa_data_num=0, batch_cnt=0, word_cnt=0, idle=0, state=INIT.
- INIT: hold everything low. Go to FILL the cycle after sa_ready is sampled 1.
- FILL:
  - s_ready = (state==FILL) && !sa_full && (cnt<MAX_BATCH) && !close_pending. Combinational from registered state and sa_full.
  - Transfer occurs when s_valid && s_ready.
  - On a transfer, the next cycle has sa_din=s_data and sa_we=1 (1-cycle registered latency), and cnt++ and word_cnt++.
  - sa_we is 0 in every cycle that has no transfer.
- Batch close, evaluated in FILL; any one condition sets close_pending:
  - cnt reaches MAX_BATCH;
  - a transfer with s_last=1;
  - timer reaches TIMEOUT while cnt>0.
- Timer: cleared on entry to FILL; counts only while cnt>0.
- Simultaneous events: a transfer and a timeout in the same cycle still accept the record; the batch includes it.
- s_last with cnt==0 is impossible because the record itself counts.
- A timeout with cnt==0 never fires.
- KICK state:
  - Entered the cycle after close_pending is set, which guarantees the last sa_we has been issued.
  - Drives sa_kick=1 and sa_data_num=cnt for exactly one cycle; batch_cnt++.
  - Then goes to WAIT.
- WAIT:
  - s_ready=0; a guard counter runs KICK_GUARD cycles.
  - After the guard, the first cycle with sa_busy==0 goes to FILL with cnt=0, close_pending=0, timer=0.
  - sa_data_num holds its value until the next kick.
- sa_full asserted mid-batch stalls acceptance only; the batch is not closed.
- idle=1 only in FILL with cnt==0.
- Reset mid-batch: immediate return to INIT with all reset values; records already in flight are dropped. The engine is reset by the same reset.

Decomposition:
- Package search_and_add_pkg holds:
  - state enum {INIT, FILL, KICK, WAIT};
  - KEY_W=128, VAL_W=32, REC_W=160, NUM_W=8;
  - typedef rec_t = struct {key, val}.
- Single module, no sub-module. Timer and guard counters are inline.

Test Plan:
- Startup gate: hold sa_ready=0 for 20 cycles after reset with s_valid=1 -> s_ready stays 0 and no sa_we. Raise sa_ready -> the first sa_we lands 2 cycles later.
- Last-closed batch: send 2 records, second with s_last (DEADBEEF…, 00C0FFEE…) -> two sa_we cycles in order, then one sa_kick cycle with sa_data_num=2. Model busy for 5 cycles -> FILL resumes; batch_cnt=1, word_cnt=2.
- Size-closed batch: MAX_BATCH=4, stream 10 records, no last -> kicks with data_num 4 and 4. The remaining 2 go out via TIMEOUT=16 with data_num=2 once the timer reaches 16 after the 9th record's acceptance.
- Backpressure: pulse sa_full for 3 cycles mid-batch -> s_ready=0 those cycles, no record lost or duplicated (scoreboard order check), data_num correct.
- Busy guard: engine asserts busy only 2 cycles after kick -> the scheduler does not leave WAIT early; the next batch's sa_we never overlaps busy=1.
- Reset mid-WAIT: assert reset during busy -> all outputs return to reset values next cycle; state INIT; counters 0.

Source files
------------

// File: rtl/search_and_add_pkg.sv
// Shared types and widths for the search_and_add batch scheduler.
package search_and_add_pkg;

  localparam int KEY_W = 128;
  localparam int VAL_W = 32;
  localparam int REC_W = KEY_W + VAL_W;
  localparam int NUM_W = 8;

  // Scheduler phases: wait for engine init, collect a batch, start it, wait for completion.
  typedef enum logic [1:0] {
    INIT = 2'd0,
    FILL = 2'd1,
    KICK = 2'd2,
    WAIT = 2'd3
  } state_e;

  // Word record as carried on the stream: key in the upper bits, count below.
  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } rec_t;

endpackage

// File: rtl/search_and_add_sched.sv
// Batch scheduler: forwards word records into the search_and_add input FIFO,
// closes a batch on size, end-of-stream or idle timeout, kicks the engine and
// waits for it to finish before collecting the next batch.
module search_and_add_sched
  import search_and_add_pkg::*;
#(
  parameter int unsigned MAX_BATCH  = 255,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned KICK_GUARD = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic [REC_W-1:0] s_data,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             sa_ready,
  output logic [REC_W-1:0] sa_din,
  output logic             sa_we,
  input  logic             sa_full,
  output logic             sa_kick,
  output logic [NUM_W-1:0] sa_data_num,
  input  logic             sa_busy,
  output logic [31:0]      batch_cnt,
  output logic [31:0]      word_cnt,
  output logic             idle
);

  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GRD_W = (KICK_GUARD > 0) ? $clog2(KICK_GUARD + 1) : 1;
  localparam logic [TMR_W-1:0] TMO_V = TMR_W'(TIMEOUT);
  localparam logic [GRD_W-1:0] GRD_V = GRD_W'(KICK_GUARD);
  localparam logic [NUM_W-1:0] MAX_V = NUM_W'(MAX_BATCH);

  state_e           state_q, state_d;
  logic [NUM_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [GRD_W-1:0] guard_q, guard_d;
  logic             close_pending_q, close_pending_d;
  rec_t             sa_din_q, sa_din_d;
  logic             sa_we_q, sa_we_d;
  logic [NUM_W-1:0] sa_data_num_q, sa_data_num_d;
  logic [31:0]      batch_cnt_q, batch_cnt_d;
  logic [31:0]      word_cnt_q, word_cnt_d;
  logic             transfer;

  // Next-state and combinational outputs for the batch FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can leave one unassigned and infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q;
    timer_d         = timer_q;
    guard_d         = guard_q;
    close_pending_d = close_pending_q;
    sa_din_d        = sa_din_q;
    sa_we_d         = 1'b0;
    sa_data_num_d   = sa_data_num_q;
    batch_cnt_d     = batch_cnt_q;
    word_cnt_d      = word_cnt_q;
    s_ready         = 1'b0;
    sa_kick         = 1'b0;
    idle            = 1'b0;
    transfer        = 1'b0;

    unique case (state_q)
      INIT: begin
        if (sa_ready) begin
          state_d         = FILL;
          cnt_d           = '0;
          timer_d         = '0;
          close_pending_d = 1'b0;
        end
      end

      FILL: begin
        idle     = (cnt_q == '0);
        s_ready  = !sa_full && (cnt_q < MAX_V) && !close_pending_q;
        transfer = s_valid && s_ready;
        if (transfer) begin
          sa_din_d   = rec_t'(s_data);
          sa_we_d    = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          word_cnt_d = word_cnt_q + 32'd1;
        end
        // Timer measures how long the oldest record of the batch has waited.
        if ((TIMEOUT != 0) && (cnt_q != '0) && !close_pending_q && (timer_q != TMO_V)) begin
          timer_d = timer_q + 1'b1;
        end
        if (transfer && (s_last || (cnt_d == MAX_V))) begin
          close_pending_d = 1'b1;
        end
        // A record accepted in the same cycle still belongs to this batch.
        if ((TIMEOUT != 0) && (cnt_q != '0) && (timer_d == TMO_V)) begin
          close_pending_d = 1'b1;
        end
        // One cycle after closing, the final FIFO write has already gone out.
        if (close_pending_q) begin
          state_d       = KICK;
          sa_data_num_d = cnt_q;
        end
      end

      KICK: begin
        sa_kick     = 1'b1;
        batch_cnt_d = batch_cnt_q + 32'd1;
        guard_d     = '0;
        state_d     = WAIT;
      end

      WAIT: begin
        // The engine may not raise busy immediately, so ignore it for a few cycles.
        if (guard_q != GRD_V) begin
          guard_d = guard_q + 1'b1;
        end else if (!sa_busy) begin
          state_d         = FILL;
          cnt_d           = '0;
          timer_d         = '0;
          close_pending_d = 1'b0;
        end
      end

      default: state_d = INIT;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
    if (reset) begin
      state_q         <= INIT;
      cnt_q           <= '0;
      timer_q         <= '0;
      guard_q         <= '0;
      close_pending_q <= 1'b0;
      sa_din_q        <= '0;
      sa_we_q         <= 1'b0;
      sa_data_num_q   <= '0;
      batch_cnt_q     <= '0;
      word_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      timer_q         <= timer_d;
      guard_q         <= guard_d;
      close_pending_q <= close_pending_d;
      sa_din_q        <= sa_din_d;
      sa_we_q         <= sa_we_d;
      sa_data_num_q   <= sa_data_num_d;
      batch_cnt_q     <= batch_cnt_d;
      word_cnt_q      <= word_cnt_d;
    end
  end

  assign sa_din      = sa_din_q;
  assign sa_we       = sa_we_q;
  assign sa_data_num = sa_data_num_q;
  assign batch_cnt   = batch_cnt_q;
  assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_search_and_add_sched.sv
// Self-checking bench for search_and_add_sched: directed scenarios plus a
// randomized stream, checked against a transaction-level batch model.
`timescale 1ns/1ps
module tb_search_and_add_sched;
  import search_and_add_pkg::*;

  localparam int MAXB  = 4;
  localparam int TMO   = 16;
  localparam int GUARD = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             s_valid;
  logic [REC_W-1:0] s_data;
  logic             s_last;
  logic             s_ready;
  logic             sa_ready;
  logic [REC_W-1:0] sa_din;
  logic             sa_we;
  logic             sa_full;
  logic             sa_kick;
  logic [NUM_W-1:0] sa_data_num;
  logic             sa_busy;
  logic [31:0]      batch_cnt;
  logic [31:0]      word_cnt;
  logic             idle;

  always #5 clk = ~clk;

  search_and_add_sched #(
    .MAX_BATCH (MAXB),
    .TIMEOUT   (TMO),
    .KICK_GUARD(GUARD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .sa_ready   (sa_ready),
    .sa_din     (sa_din),
    .sa_we      (sa_we),
    .sa_full    (sa_full),
    .sa_kick    (sa_kick),
    .sa_data_num(sa_data_num),
    .sa_busy    (sa_busy),
    .batch_cnt  (batch_cnt),
    .word_cnt   (word_cnt),
    .idle       (idle)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: accepted records awaiting write, accept edges of
  // the open batch, and a log of kicked batch sizes.
  logic [REC_W-1:0] exp_data_q[$];
  int               acc_t_q[$];
  bit               acc_last_q[$];
  int               kick_log[$];
  int               n_acc, n_kick, n_wr_batch, first_we_cyc, last_kick_cyc;
  bit               hs_seen, busy_on, rand_full;
  int               busy_dly, busy_len;

  task automatic check(input string tag, input logic [REC_W-1:0] obs, input logic [REC_W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] rand_rec();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Batch rule: starting from the first pending record, include records until
  // one carries last, the batch holds MAXB, or TMO edges have passed since the
  // first accept (a record accepted on that edge still counts). Kick follows
  // one cycle after the closing edge.
  task automatic model_kick();
    int t0, close_edge, n;
    n = 0;
    if (acc_t_q.size() == 0) begin
      check("kick_without_records", REC_W'(sa_kick), REC_W'(0));
      return;
    end
    t0         = acc_t_q[0];
    close_edge = t0 + TMO;
    for (int i = 0; i < acc_t_q.size(); i++) begin
      if (acc_t_q[i] > close_edge) break;
      n++;
      if (acc_last_q[i] || n == MAXB) begin
        close_edge = acc_t_q[i];
        break;
      end
    end
    check("data_num", REC_W'(sa_data_num), REC_W'(n));
    check("kick_cycle", REC_W'(cyc), REC_W'(close_edge + 1));
    check("writes_in_batch", REC_W'(n_wr_batch), REC_W'(n));
    for (int i = 0; i < n; i++) begin
      void'(acc_t_q.pop_front());
      void'(acc_last_q.pop_front());
    end
  endtask

  // One clock: observe on the falling edge, then advance to just past the
  // rising edge and update the engine busy model.
  task automatic tick();
    int k;
    @(negedge clk);
    if (!reset) begin
      if (sa_we) begin
        if (exp_data_q.size() == 0) begin
          check("write_without_accept", REC_W'(sa_we), REC_W'(0));
        end else begin
          check("sa_din_order", sa_din, exp_data_q.pop_front());
          n_wr_batch++;
          if (first_we_cyc < 0) first_we_cyc = cyc;
        end
      end
      if (sa_full) check("s_ready_while_full", REC_W'(s_ready), REC_W'(0));
      if (sa_busy) begin
        check("we_while_busy", REC_W'(sa_we), REC_W'(0));
        check("ready_while_busy", REC_W'(s_ready), REC_W'(0));
        check("idle_while_busy", REC_W'(idle), REC_W'(0));
      end
      if (sa_kick) begin
        model_kick();
        n_kick++;
        kick_log.push_back(int'(sa_data_num));
        last_kick_cyc = cyc;
        busy_on       = 1'b1;
        n_wr_batch    = 0;
      end
      if (s_valid && s_ready) begin
        exp_data_q.push_back(s_data);
        acc_t_q.push_back(cyc + 1);
        acc_last_q.push_back(s_last);
        n_acc++;
        hs_seen = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (reset) begin
      busy_on = 1'b0;
      sa_busy = 1'b0;
    end else if (busy_on) begin
      k       = cyc - last_kick_cyc;
      sa_busy = (k >= busy_dly) && (k < busy_dly + busy_len);
      if (k >= busy_dly + busy_len) busy_on = 1'b0;
    end
    if (rand_full) sa_full = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send_rec(input logic [REC_W-1:0] d, input bit last);
    int w;
    w       = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    hs_seen = 1'b0;
    while (!hs_seen && w < 200) begin
      tick();
      w++;
    end
    check("handshake_timeout", REC_W'(hs_seen), REC_W'(1));
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_kicks(input int target);
    int w;
    w = 0;
    while (n_kick < target && w < 300) begin
      tick();
      w++;
    end
    check("kick_timeout", REC_W'(n_kick >= target), REC_W'(1));
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!idle && w < 300) begin
      tick();
      w++;
    end
    check("idle_reached", REC_W'(idle), REC_W'(1));
  endtask

  task automatic check_reset_vals();
    check("rst_s_ready", REC_W'(s_ready), REC_W'(0));
    check("rst_sa_we", REC_W'(sa_we), REC_W'(0));
    check("rst_sa_kick", REC_W'(sa_kick), REC_W'(0));
    check("rst_sa_din", sa_din, REC_W'(0));
    check("rst_data_num", REC_W'(sa_data_num), REC_W'(0));
    check("rst_batch_cnt", REC_W'(batch_cnt), REC_W'(0));
    check("rst_word_cnt", REC_W'(word_cnt), REC_W'(0));
    check("rst_idle", REC_W'(idle), REC_W'(0));
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_last  = 1'b0;
    reset   = 1'b1;
    tick();
    tick();
    check_reset_vals();
    exp_data_q.delete();
    acc_t_q.delete();
    acc_last_q.delete();
    kick_log.delete();
    n_acc        = 0;
    n_kick       = 0;
    n_wr_batch   = 0;
    first_we_cyc = -1;
    reset        = 1'b0;
  endtask

  initial begin
    rec_t r;
    int   c, base, k0, w, total;

    reset     = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    sa_ready  = 1'b0;
    sa_full   = 1'b0;
    sa_busy   = 1'b0;
    rand_full = 1'b0;
    busy_on   = 1'b0;
    busy_dly  = 1;
    busy_len  = 5;
    @(posedge clk);
    #1;

    // Startup gate: engine not ready, upstream offering data.
    do_reset();
    s_valid = 1'b1;
    s_data  = rand_rec();
    s_last  = 1'b0;
    repeat (20) begin
      tick();
      check("gate_s_ready", REC_W'(s_ready), REC_W'(0));
      check("gate_sa_we", REC_W'(sa_we), REC_W'(0));
    end
    check("gate_idle", REC_W'(idle), REC_W'(0));
    sa_ready     = 1'b1;
    c            = cyc;
    first_we_cyc = -1;
    send_rec(s_data, 1'b1);
    w = 0;
    while (first_we_cyc < 0 && w < 20) begin
      tick();
      w++;
    end
    check("first_we_latency", REC_W'(first_we_cyc), REC_W'(c + 2));
    wait_kicks(1);
    wait_idle();

    // Last-closed batch of two records.
    do_reset();
    r.key = {4{32'hDEADBEEF}};
    r.val = 32'h0000_0001;
    send_rec(r, 1'b0);
    r.key = {4{32'h00C0FFEE}};
    r.val = 32'h0000_0002;
    send_rec(r, 1'b1);
    wait_kicks(1);
    check("last_batch_num", REC_W'(kick_log[0]), REC_W'(2));
    wait_idle();
    check("last_batch_cnt", REC_W'(batch_cnt), REC_W'(1));
    check("last_word_cnt", REC_W'(word_cnt), REC_W'(2));

    // Size-closed batches; the tail leaves through the timeout.
    for (int i = 0; i < 10; i++) send_rec(rand_rec(), 1'b0);
    wait_kicks(4);
    check("size_batch_a", REC_W'(kick_log[1]), REC_W'(4));
    check("size_batch_b", REC_W'(kick_log[2]), REC_W'(4));
    check("timeout_batch", REC_W'(kick_log[3]), REC_W'(2));
    wait_idle();
    check("size_word_cnt", REC_W'(word_cnt), REC_W'(12));
    check("size_batch_cnt", REC_W'(batch_cnt), REC_W'(4));

    // Backpressure mid-batch.
    base = n_kick;
    send_rec(rand_rec(), 1'b0);
    send_rec(rand_rec(), 1'b0);
    s_valid = 1'b1;
    s_data  = rand_rec();
    s_last  = 1'b0;
    sa_full = 1'b1;
    repeat (3) begin
      tick();
      check("bp_s_ready", REC_W'(s_ready), REC_W'(0));
    end
    sa_full = 1'b0;
    send_rec(s_data, 1'b0);
    send_rec(rand_rec(), 1'b1);
    wait_kicks(base + 1);
    check("bp_batch_num", REC_W'(kick_log[base]), REC_W'(4));
    wait_idle();

    // Engine raises busy late; the scheduler must not resume early.
    busy_dly = 2;
    busy_len = 4;
    base     = n_kick;
    send_rec(rand_rec(), 1'b0);
    send_rec(rand_rec(), 1'b1);
    wait_kicks(base + 1);
    k0           = last_kick_cyc;
    first_we_cyc = -1;
    send_rec(rand_rec(), 1'b1);
    wait_kicks(base + 2);
    check("guard_we_after_busy", REC_W'(first_we_cyc > k0 + busy_dly + busy_len - 1), REC_W'(1));
    wait_idle();

    // Reset while the engine is busy.
    busy_dly = 1;
    busy_len = 8;
    send_rec(rand_rec(), 1'b1);
    wait_kicks(n_kick + 1);
    tick();
    tick();
    do_reset();
    wait_idle();

    // Randomized stream with random backpressure, last flags and idle gaps.
    busy_len  = 3;
    rand_full = 1'b1;
    for (int i = 0; i < 60; i++) begin
      int gap;
      gap = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 2));
      repeat (gap) tick();
      send_rec(rand_rec(), ($urandom_range(0, 7) == 0));
    end
    rand_full = 1'b0;
    sa_full   = 1'b0;
    w = 0;
    while ((acc_t_q.size() != 0 || !idle) && w < 500) begin
      tick();
      w++;
    end
    check("rand_drain", REC_W'(acc_t_q.size()), REC_W'(0));
    check("rand_word_cnt", REC_W'(word_cnt), REC_W'(n_acc));
    check("rand_batch_cnt", REC_W'(batch_cnt), REC_W'(n_kick));
    total = 0;
    foreach (kick_log[i]) total += kick_log[i];
    check("rand_kicked_total", REC_W'(total), REC_W'(n_acc));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
